// File: rtl/lifo_stack.sv
// Parametrised synchronous LIFO stack with occupancy count, combinational top-of-stack peek,
// same-cycle replace-top/bypass, and sticky overflow/underflow flags.
module lifo_stack #(
    parameter  int WIDTH = 12,
    parameter  int DEPTH = 8,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] in,
    input  logic             clr_err,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic [WIDTH-1:0] top_data,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    count_m1;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    top_idx;
    logic             push_ok;
    logic             pop_ok;
    logic             replace;
    logic             bypass;
    logic             ovf_evt;
    logic             unf_evt;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign count_m1 = count - CW'(1);

    // Indices are only dereferenced when in range (push not full, top not empty).
    assign wr_idx   = count[AW-1:0];
    assign top_idx  = count_m1[AW-1:0];
    assign top_data = empty ? '0 : mem[top_idx];

    assign push_ok  = push & ~pop & ~full;
    assign pop_ok   = pop & ~push & ~empty;
    assign replace  = push & pop & ~empty;
    assign bypass   = push & pop & empty;
    assign ovf_evt  = push & ~pop & full;
    assign unf_evt  = pop & ~push & empty;

    // Storage is deliberately not reset; count alone defines what is valid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (push_ok) begin
                mem[wr_idx] <= in;
            end else if (replace) begin
                mem[top_idx] <= in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            out_valid <= pop_ok | replace | bypass;
            if (push_ok) begin
                count <= count + CW'(1);
            end else if (pop_ok) begin
                count <= count_m1;
            end
            if (pop_ok || replace) begin
                out <= mem[top_idx];
            end else if (bypass) begin
                out <= in;
            end
            // A same-cycle error event takes precedence over clr_err.
            overflow  <= (overflow  & ~clr_err) | ovf_evt;
            underflow <= (underflow & ~clr_err) | unf_evt;
        end
    end
endmodule

// File: tb/tb_lifo_stack.sv
// Bench for lifo_stack: directed scenarios followed by random traffic, all checked
// against a queue-based model of the stack.
module tb_lifo_stack;
    localparam int WIDTH = 12;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic [WIDTH-1:0] in = '0;
    logic             clr_err = 1'b0;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic [WIDTH-1:0] top_data;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    lifo_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .in(in), .clr_err(clr_err),
        .out(out), .out_valid(out_valid), .top_data(top_data), .count(count),
        .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_out   = '0;
    logic             m_valid = 1'b0;
    logic             m_ovf   = 1'b0;
    logic             m_unf   = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update(input logic p, input logic o, input logic [WIDTH-1:0] d,
                                input logic c, input logic r);
        int sz;
        logic ovf_e, unf_e;
        sz = q.size();
        if (r) begin
            q.delete();
            m_out = '0; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
            return;
        end
        ovf_e = p && !o && sz == DEPTH;
        unf_e = o && !p && sz == 0;
        m_valid = 1'b0;
        if (p && !o) begin
            if (sz < DEPTH) q.push_back(d);
        end else if (o && !p) begin
            if (sz > 0) begin
                m_out = q.pop_back();
                m_valid = 1'b1;
            end
        end else if (p && o) begin
            if (sz > 0) begin
                m_out = q[sz-1];
                q[sz-1] = d;
            end else begin
                m_out = d;
            end
            m_valid = 1'b1;
        end
        if (c) begin
            m_ovf = 1'b0; m_unf = 1'b0;
        end
        if (ovf_e) m_ovf = 1'b1;
        if (unf_e) m_unf = 1'b1;
    endtask

    task automatic compare_all();
        int sz;
        sz = q.size();
        check_eq("count",     32'(count),     32'(sz));
        check_eq("empty",     32'(empty),     32'(sz == 0));
        check_eq("full",      32'(full),      32'(sz == DEPTH));
        check_eq("top_data",  32'(top_data),  (sz > 0) ? 32'(q[sz-1]) : 32'd0);
        check_eq("out",       32'(out),       32'(m_out));
        check_eq("out_valid", 32'(out_valid), 32'(m_valid));
        check_eq("overflow",  32'(overflow),  32'(m_ovf));
        check_eq("underflow", 32'(underflow), 32'(m_unf));
    endtask

    // One clock: drive inputs, take the edge, advance the model, compare 1 ns later.
    task automatic step(input logic p, input logic o, input logic [WIDTH-1:0] d,
                        input logic c, input logic r);
        push = p; pop = o; in = d; clr_err = c; rst = r;
        @(posedge clk);
        model_update(p, o, d, c, r);
        #1;
        compare_all();
    endtask

    initial begin
        step(0, 0, '0, 0, 1);
        step(0, 0, '0, 0, 1);
        check_eq("rst_count", 32'(count), 32'd0);

        // Fill, then overflow
        for (int i = 1; i <= DEPTH; i++) step(1, 0, WIDTH'(i), 0, 0);
        check_eq("fill_top", 32'(top_data), 32'h008);
        step(1, 0, 12'hFFF, 0, 0);
        check_eq("ovf_set", 32'(overflow), 32'd1);
        check_eq("ovf_top", 32'(top_data), 32'h008);

        // Drain back-to-back, then underflow
        for (int i = DEPTH; i >= 1; i--) begin
            step(0, 1, '0, 0, 0);
            check_eq("drain_out", 32'(out), 32'(i));
        end
        step(0, 1, '0, 0, 0);
        check_eq("unf_set", 32'(underflow), 32'd1);
        check_eq("unf_out", 32'(out), 32'h001);

        // Replace-top
        step(0, 0, '0, 1, 0);
        step(1, 0, 12'h0AA, 0, 0);
        step(1, 1, 12'h0BB, 0, 0);
        check_eq("repl_out", 32'(out), 32'h0AA);
        check_eq("repl_top", 32'(top_data), 32'h0BB);
        for (int i = 0; i < DEPTH - 1; i++) step(1, 0, WIDTH'(12'h300 + i), 0, 0);
        step(1, 1, 12'h123, 0, 0);
        check_eq("repl_full_cnt", 32'(count), 32'(DEPTH));
        check_eq("repl_full_ovf", 32'(overflow), 32'd0);

        // Bypass when empty
        for (int i = 0; i < DEPTH; i++) step(0, 1, '0, 0, 0);
        step(1, 1, 12'h5A5, 0, 0);
        check_eq("byp_out", 32'(out), 32'h5A5);
        check_eq("byp_cnt", 32'(count), 32'd0);

        // clr_err alone, then clr_err colliding with an overflow event
        for (int i = 0; i < DEPTH; i++) step(1, 0, WIDTH'(i), 0, 0);
        step(1, 0, 12'h111, 0, 0);
        step(0, 0, '0, 1, 0);
        check_eq("clr_ovf", 32'(overflow), 32'd0);
        step(1, 0, 12'h222, 1, 0);
        check_eq("clr_vs_ovf", 32'(overflow), 32'd1);

        // Reset mid-sequence with a concurrent pop
        step(0, 0, '0, 1, 1);
        for (int i = 0; i < 3; i++) step(1, 0, WIDTH'(12'h700 + i), 0, 0);
        step(0, 1, '0, 0, 1);
        check_eq("rst_pop_cnt", 32'(count), 32'd0);
        check_eq("rst_pop_valid", 32'(out_valid), 32'd0);

        // Random traffic in phases biased toward filling or draining
        for (int ph = 0; ph < 40; ph++) begin
            int bias;
            bias = $urandom_range(0, 2);
            for (int k = 0; k < 40; k++) begin
                int r;
                logic p, o, c, rr;
                r  = $urandom_range(0, 99);
                p  = (bias == 0) ? (r < 70) : (bias == 1) ? (r < 30) : (r < 50);
                o  = ($urandom_range(0, 99) < ((bias == 0) ? 25 : (bias == 1) ? 70 : 50));
                c  = ($urandom_range(0, 19) == 0);
                rr = ($urandom_range(0, 299) == 0);
                step(p, o, WIDTH'($urandom), c, rr);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
